// File: rtl/byte_serializer.sv
// Serializes a four-byte word (I1..I4) onto a valid/ready byte stream, holding one word
// and accepting the next on the edge its last byte leaves. Optional: BYTE_SERIALIZER_PARITY_EN.
module byte_serializer #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       I1,
    input  logic [7:0]       I2,
    input  logic [7:0]       I3,
    input  logic [7:0]       I4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
`ifdef BYTE_SERIALIZER_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic {IDLE, SEND} state_e;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        hold_q, hold_d;
    logic [7:0]         byte_q, byte_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        in_word;
    logic               xfer, last_xfer, accept;

    // Position k in emission order maps to a byte lane of the word.
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] k);
        logic [1:0] j;
        j = MSB_FIRST ? (2'd3 - k) : k;
        return w[{j, 3'b000} +: 8];
    endfunction

    assign in_word   = {I1, I2, I3, I4};
    assign xfer      = (state_q == SEND) & out_ready;
    assign last_xfer = xfer & (idx_q == 2'd3);
    assign in_ready  = (state_q == IDLE) | last_xfer;
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        byte_d  = byte_q;
        cnt_d   = cnt_q;
        if (xfer && idx_q != 2'd3) begin
            idx_d  = idx_q + 2'd1;
            byte_d = pick(hold_q, idx_q + 2'd1);
        end
        if (last_xfer) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
        end
        // A load on the last-byte edge overrides the return to IDLE: no bubble.
        if (accept) begin
            hold_d  = in_word;
            idx_d   = 2'd0;
            state_d = SEND;
            byte_d  = pick(in_word, 2'd0);
        end
    end

`ifdef BYTE_SERIALIZER_PARITY_EN
    logic parity_q;
    assign out_parity = parity_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            hold_q   <= 32'd0;
            byte_q   <= 8'd0;
            cnt_q    <= '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
            parity_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
`ifdef BYTE_SERIALIZER_PARITY_EN
            parity_q <= ~^byte_d;
`endif
        end
    end

    assign out_valid = (state_q == SEND);
    assign busy      = out_valid;
    assign out_last  = out_valid & (idx_q == 2'd3);
    assign out_byte  = byte_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: an MSB-first/16-bit-count instance and an LSB-first/2-bit-count
// instance share stimulus and are checked against a word-queue reference model.
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] i1 = 8'd0, i2 = 8'd0, i3 = 8'd0, i4 = 8'd0;

    logic        a_ir, a_ov, a_last, a_busy;
    logic [7:0]  a_byte;
    logic [15:0] a_cnt;
    logic        b_ir, b_ov, b_last, b_busy;
    logic [7:0]  b_byte;
    logic [1:0]  b_cnt;
`ifdef BYTE_SERIALIZER_PARITY_EN
    logic        a_par, b_par;
`endif

    byte_serializer #(.MSB_FIRST(1'b1), .CNT_W(16)) ua (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ir),
        .I1(i1), .I2(i2), .I3(i3), .I4(i4),
        .out_valid(a_ov), .out_ready(out_ready), .out_byte(a_byte),
        .out_last(a_last), .busy(a_busy), .word_cnt(a_cnt)
`ifdef BYTE_SERIALIZER_PARITY_EN
        , .out_parity(a_par)
`endif
    );

    byte_serializer #(.MSB_FIRST(1'b0), .CNT_W(2)) ub (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ir),
        .I1(i1), .I2(i2), .I3(i3), .I4(i4),
        .out_valid(b_ov), .out_ready(out_ready), .out_byte(b_byte),
        .out_last(b_last), .busy(b_busy), .word_cnt(b_cnt)
`ifdef BYTE_SERIALIZER_PARITY_EN
        , .out_parity(b_par)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wq[$];     // words loaded in the DUT (model)
    int          pos = 0;   // bytes of wq[0] already transferred
    int          cnt = 0;   // words completed
    logic [31:0] sq[$];     // words waiting to be offered upstream
    bit          rnd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit          ov, ir;
        logic [31:0] w;
        logic [7:0]  ea, eb;
        ov = (wq.size() > 0);
        ir = !ov || (pos == 3 && out_ready);
        chk("a_out_valid", {31'd0, a_ov}, {31'd0, ov});
        chk("b_out_valid", {31'd0, b_ov}, {31'd0, ov});
        chk("a_busy", {31'd0, a_busy}, {31'd0, ov});
        chk("a_in_ready", {31'd0, a_ir}, {31'd0, ir});
        chk("b_in_ready", {31'd0, b_ir}, {31'd0, ir});
        chk("a_out_last", {31'd0, a_last}, {31'd0, ov && pos == 3});
        chk("b_out_last", {31'd0, b_last}, {31'd0, ov && pos == 3});
        chk("a_word_cnt", {16'd0, a_cnt}, cnt % 65536);
        chk("b_word_cnt", {30'd0, b_cnt}, cnt % 4);
        if (ov) begin
            w  = wq[0];
            ea = w[8*(3-pos) +: 8];
            eb = w[8*pos +: 8];
            chk("a_out_byte", {24'd0, a_byte}, {24'd0, ea});
            chk("b_out_byte", {24'd0, b_byte}, {24'd0, eb});
`ifdef BYTE_SERIALIZER_PARITY_EN
            chk("a_out_parity", {31'd0, a_par}, {31'd0, ~^ea});
            chk("b_out_parity", {31'd0, b_par}, {31'd0, ~^eb});
`endif
        end
    endtask

    // One cycle: drive at negedge, check, then advance the model at the posedge.
    task automatic tick(input bit ordy);
        bit ov, ir, acc;
        out_ready = ordy;
        in_valid  = (sq.size() > 0);
        if (in_valid)  {i1, i2, i3, i4} = sq[0];
        else if (rnd)  {i1, i2, i3, i4} = $urandom;
        else           {i1, i2, i3, i4} = 32'd0;
        #1 check_all();
        ov  = (wq.size() > 0);
        ir  = !ov || (pos == 3 && ordy);
        acc = in_valid && ir;
        @(posedge clk);
        if (ov && ordy) begin
            if (pos == 3) begin
                void'(wq.pop_front());
                pos = 0;
                cnt++;
            end else pos++;
        end
        if (acc) wq.push_back(sq.pop_front());
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_out_valid", {31'd0, a_ov}, 32'd0);
        chk("rst_b_out_valid", {31'd0, b_ov}, 32'd0);
        chk("rst_a_in_ready", {31'd0, a_ir}, 32'd1);
        chk("rst_a_out_last", {31'd0, a_last}, 32'd0);
        chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_a_out_byte", {24'd0, a_byte}, 32'd0);
        chk("rst_a_word_cnt", {16'd0, a_cnt}, 32'd0);
        chk("rst_b_word_cnt", {30'd0, b_cnt}, 32'd0);
`ifdef BYTE_SERIALIZER_PARITY_EN
        chk("rst_a_out_parity", {31'd0, a_par}, 32'd1);
`endif
        @(negedge clk);
        reset = 1'b1;

        // single word
        sq.push_back(32'h010307F0);
        repeat (6) tick(1'b1);

        // back-to-back words, in_valid held across both
        sq.push_back(32'h010307F0);
        sq.push_back(32'h01020304);
        repeat (10) tick(1'b1);

        // backpressure while the second byte is shown; inputs read 00 meanwhile
        sq.push_back(32'hAABBCCDD);
        tick(1'b1);
        tick(1'b1);
        repeat (3) tick(1'b0);
        repeat (5) tick(1'b1);

        // parity pattern
        sq.push_back(32'h000103FF);
        repeat (6) tick(1'b1);

        // asynchronous reset mid-word
        sq.push_back(32'h11223344);
        repeat (3) tick(1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_a_out_valid", {31'd0, a_ov}, 32'd0);
        chk("midrst_b_out_valid", {31'd0, b_ov}, 32'd0);
        chk("midrst_a_word_cnt", {16'd0, a_cnt}, 32'd0);
        chk("midrst_b_word_cnt", {30'd0, b_cnt}, 32'd0);
        chk("midrst_a_out_last", {31'd0, a_last}, 32'd0);
        wq.delete();
        sq.delete();
        pos = 0;
        cnt = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        sq.push_back(32'h55667788);
        repeat (6) tick(1'b1);

        // random traffic with random backpressure
        rnd = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (sq.size() == 0 && $urandom_range(0, 2) != 0) sq.push_back($urandom);
            tick($urandom_range(0, 3) != 0);
        end
        repeat (12) tick(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
